// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and the IF/ID register, with stall and flush.
// Optional performance counters (stall_cnt, flush_cnt, perf_clr) are built when FETCH_PERF_EN is defined.

// state | meaning
// BOOT  | first cycle after reset; pc parked at RESET_PC, IF/ID kept as a bubble
// RUN   | normal fetch with flush > hazard > advance priority
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      nxt_pc,
  input  logic             hazard,
  input  logic             flush,
  input  logic [15:0]      imem_rdata,
  output logic [15:0]      pc,
  output logic [15:0]      imem_addr,
  output logic [15:0]      if_pc,
  output logic [15:0]      if_instr,
  output logic             if_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  input  logic             perf_clr
`endif
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t state;

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      if_pc    <= 16'h0000;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (flush) begin
            pc       <= nxt_pc;
            if_pc    <= pc;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
          end else if (!hazard) begin
            pc       <= nxt_pc;
            if_pc    <= pc;
            if_instr <= imem_rdata;
            if_valid <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Both counters saturate; a clear wins over an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state == RUN) begin
      if (flush) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end else if (hazard) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
